// File: rtl/register_bank.sv
// MIPS general-purpose register file: write-back write port, two combinational read ports,
// and a handshaked dump port. Optional define REGBANK_WR_BYPASS_EN forwards same-cycle writes to the read ports.
module register_bank #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_ADDR-1:0] i_addr_rs,
    input  logic [NB_ADDR-1:0] i_addr_rt,
    output logic [NB_DATA-1:0] o_data_rs,
    output logic [NB_DATA-1:0] o_data_rt,
    input  logic [NB_ADDR-1:0] i_addr_reg_dst,
    input  logic [NB_DATA-1:0] i_reg_dst,
    input  logic               is_RegWrite,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_done
);

    localparam int N_REGS = 2**NB_ADDR;
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [NB_DATA-1:0] regs [N_REGS];

    state_t             state;
    state_t             state_next;
    logic               valid_next;
    logic [NB_ADDR-1:0] addr_next;
    logic [NB_DATA-1:0] data_next;
    logic               done_next;
    logic [NB_ADDR-1:0] addr_inc;
    logic               write_en;

    // Register 0 is never written, so it stays at its reset value of zero.
    assign write_en = is_RegWrite && (i_addr_reg_dst != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[i_addr_reg_dst] <= i_reg_dst;
        end
    end

`ifdef REGBANK_WR_BYPASS_EN
    assign o_data_rs = (write_en && (i_addr_reg_dst == i_addr_rs)) ? i_reg_dst : regs[i_addr_rs];
    assign o_data_rt = (write_en && (i_addr_reg_dst == i_addr_rt)) ? i_reg_dst : regs[i_addr_rt];
`else
    assign o_data_rs = regs[i_addr_rs];
    assign o_data_rt = regs[i_addr_rt];
`endif

    assign addr_inc = o_dump_addr + 1'b1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            o_dump_valid <= 1'b0;
            o_dump_addr  <= '0;
            o_dump_data  <= '0;
            o_dump_done  <= 1'b0;
        end else begin
            state        <= state_next;
            o_dump_valid <= valid_next;
            o_dump_addr  <= addr_next;
            o_dump_data  <= data_next;
            o_dump_done  <= done_next;
        end
    end

    // Dump data is sampled from the stored array, so a write on the same edge is not seen.
    always_comb begin
        state_next = state;
        valid_next = o_dump_valid;
        addr_next  = o_dump_addr;
        data_next  = o_dump_data;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (i_dump_start) begin
                    state_next = SEND;
                    valid_next = 1'b1;
                    addr_next  = '0;
                    data_next  = regs[0];
                end
            end
            SEND: begin
                if (o_dump_valid && i_dump_ready) begin
                    if (o_dump_addr == LAST_ADDR) begin
                        state_next = DONE;
                        valid_next = 1'b0;
                        addr_next  = '0;
                        data_next  = '0;
                        done_next  = 1'b1;
                    end else begin
                        addr_next = addr_inc;
                        data_next = regs[addr_inc];
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                valid_next = 1'b0;
                addr_next  = '0;
                data_next  = '0;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                addr_next  = '0;
                data_next  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: vector table, randomized reads/writes against
// an array model, and hand-written dump sequences (ready toggling, reset mid-dump).
module tb_register_bank;

    logic        i_clk;
    logic        i_reset;
    logic [4:0]  i_addr_rs;
    logic [4:0]  i_addr_rt;
    logic [31:0] o_data_rs;
    logic [31:0] o_data_rt;
    logic [4:0]  i_addr_reg_dst;
    logic [31:0] i_reg_dst;
    logic        is_RegWrite;
    logic        i_dump_start;
    logic        i_dump_ready;
    logic        o_dump_valid;
    logic [4:0]  o_dump_addr;
    logic [31:0] o_dump_data;
    logic        o_dump_done;

    register_bank dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_addr_rs      (i_addr_rs),
        .i_addr_rt      (i_addr_rt),
        .o_data_rs      (o_data_rs),
        .o_data_rt      (o_data_rt),
        .i_addr_reg_dst (i_addr_reg_dst),
        .i_reg_dst      (i_reg_dst),
        .is_RegWrite    (is_RegWrite),
        .i_dump_start   (i_dump_start),
        .i_dump_ready   (i_dump_ready),
        .o_dump_valid   (o_dump_valid),
        .o_dump_addr    (o_dump_addr),
        .o_dump_data    (o_dump_data),
        .o_dump_done    (o_dump_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] ers;
        logic [31:0] ert;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] model [32];
    int          checks;
    int          errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_write(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (we && wa != 5'd0) model[wa] = wd;
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
        is_RegWrite    = 1'b1;
        i_addr_reg_dst = wa;
        i_reg_dst      = wd;
        step();
        is_RegWrite    = 1'b0;
        model_write(1'b1, wa, wd);
    endtask

    initial begin
        int n;
        int idx;
        int cyc;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd6,  32'hFFFFFFFF, 5'd6,  5'd0,  32'h00000000, 32'h00000000};
        vecs[3] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 5'd5,  32'h00000000, 5'd5,  5'd1,  32'h00000000, 32'h00000001};

        i_reset        = 1'b1;
        i_addr_rs      = 5'd0;
        i_addr_rt      = 5'd0;
        i_addr_reg_dst = 5'd0;
        i_reg_dst      = 32'd0;
        is_RegWrite    = 1'b0;
        i_dump_start   = 1'b0;
        i_dump_ready   = 1'b0;
        repeat (2) step();
        i_reset = 1'b0;
        step();

        // Reset state: every register reads zero, dump port idle.
        for (int i = 0; i < 32; i++) begin
            i_addr_rs = 5'(i);
            i_addr_rt = 5'(31 - i);
            #1;
            check("reset_rs", o_data_rs, 32'd0);
            check("reset_rt", o_data_rt, 32'd0);
        end
        check("reset_valid", 32'(o_dump_valid), 32'd0);
        check("reset_addr",  32'(o_dump_addr),  32'd0);
        check("reset_data",  o_dump_data,        32'd0);
        check("reset_done",  32'(o_dump_done),  32'd0);

        // Vector table: values read back one edge after the write.
        for (int v = 0; v < 6; v++) begin
            is_RegWrite    = vecs[v].we;
            i_addr_reg_dst = vecs[v].wa;
            i_reg_dst      = vecs[v].wd;
            i_addr_rs      = vecs[v].rs;
            i_addr_rt      = vecs[v].rt;
            step();
            model_write(vecs[v].we, vecs[v].wa, vecs[v].wd);
            check("vec_rs", o_data_rs, vecs[v].ers);
            check("vec_rt", o_data_rt, vecs[v].ert);
        end
        is_RegWrite = 1'b0;

        // Same-cycle write and read of r7.
        wr(5'd7, 32'h11111111);
        i_addr_rs      = 5'd7;
        is_RegWrite    = 1'b1;
        i_addr_reg_dst = 5'd7;
        i_reg_dst      = 32'hA5A5A5A5;
        #1;
`ifdef REGBANK_WR_BYPASS_EN
        check("same_cycle_rs", o_data_rs, 32'hA5A5A5A5);
`else
        check("same_cycle_rs", o_data_rs, 32'h11111111);
`endif
        step();
        is_RegWrite = 1'b0;
        model_write(1'b1, 5'd7, 32'hA5A5A5A5);
        check("after_edge_rs", o_data_rs, 32'hA5A5A5A5);

        // Randomized traffic, reads checked before the edge that performs the write.
        for (int k = 0; k < 300; k++) begin
            is_RegWrite    = ($urandom_range(0, 1) == 1);
            i_addr_reg_dst = 5'($urandom_range(0, 31));
            i_reg_dst      = $urandom;
            i_addr_rs      = ($urandom_range(0, 3) == 0) ? i_addr_reg_dst : 5'($urandom_range(0, 31));
            i_addr_rt      = 5'($urandom_range(0, 31));
            #1;
            exp_rs = model[i_addr_rs];
            exp_rt = model[i_addr_rt];
`ifdef REGBANK_WR_BYPASS_EN
            if (is_RegWrite && i_addr_reg_dst != 5'd0 && i_addr_reg_dst == i_addr_rs) exp_rs = i_reg_dst;
            if (is_RegWrite && i_addr_reg_dst != 5'd0 && i_addr_reg_dst == i_addr_rt) exp_rt = i_reg_dst;
`endif
            check("rand_rs", o_data_rs, exp_rs);
            check("rand_rt", o_data_rt, exp_rt);
            step();
            model_write(is_RegWrite, i_addr_reg_dst, i_reg_dst);
        end
        is_RegWrite = 1'b0;

        // Dump with ready toggling 1,0,1,0 and a stray start pulse mid-dump.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3));
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 32 && cyc < 200) begin
            i_dump_ready = (cyc % 2 == 0);
            i_dump_start = (cyc == 5);
            check("dump_valid", 32'(o_dump_valid), 32'd1);
            check("dump_addr",  32'(o_dump_addr),  32'(idx));
            check("dump_data",  o_dump_data,        32'(idx * 3));
            check("dump_done_low", 32'(o_dump_done), 32'd0);
            step();
            if (i_dump_ready) idx++;
            cyc++;
        end
        i_dump_start = 1'b0;
        i_dump_ready = 1'b0;
        check("dump_word_count", 32'(idx), 32'd32);
        check("dump_done_pulse", 32'(o_dump_done),  32'd1);
        check("dump_done_valid", 32'(o_dump_valid), 32'd0);
        step();
        check("dump_done_clear", 32'(o_dump_done), 32'd0);
        check("dump_idle_addr",  32'(o_dump_addr), 32'd0);
        check("dump_idle_data",  o_dump_data,       32'd0);
        check("dump_idle_valid", 32'(o_dump_valid), 32'd0);

        // Reset asserted mid-dump at addr 10.
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        i_dump_ready = 1'b1;
        n = 0;
        while (o_dump_addr != 5'd10 && n < 100) begin
            step();
            n++;
        end
        check("reach_addr10", 32'(o_dump_addr), 32'd10);
        #2;
        i_reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        i_addr_rs = 5'd3;
        i_addr_rt = 5'd30;
        #1;
        check("rst_mid_valid", 32'(o_dump_valid), 32'd0);
        check("rst_mid_addr",  32'(o_dump_addr),  32'd0);
        check("rst_mid_data",  o_dump_data,        32'd0);
        check("rst_mid_rs",    o_data_rs,          32'd0);
        check("rst_mid_rt",    o_data_rt,          32'd0);
        i_dump_ready = 1'b0;
        step();
        i_reset = 1'b0;
        step();
        check("rst_idle_valid", 32'(o_dump_valid), 32'd0);

        // Restart at addr 0; a write on the loading edge is not seen by the dump.
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        check("restart_valid", 32'(o_dump_valid), 32'd1);
        check("restart_addr",  32'(o_dump_addr),  32'd0);
        check("restart_data",  o_dump_data,        32'd0);
        i_dump_ready = 1'b1;
        wr(5'd1, 32'h00000077);
        check("prewrite_addr", 32'(o_dump_addr), 32'd1);
        check("prewrite_data", o_dump_data,       32'd0);
        i_addr_rs = 5'd1;
        #1;
        check("write_not_blocked", o_data_rs, model[1]);
        n = 0;
        while (!o_dump_done && n < 100) begin
            step();
            n++;
        end
        check("restart_done", 32'(o_dump_done), 32'd1);
        i_dump_ready = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
